// File: rtl/pwm_pkg.sv
// pwm_pkg
//   Shared definitions for the PWM gate-drive blocks and their benches.
//   - pwm_state_e : dead-time FSM state encodings (IDLE/HI_ON/LO_ON/DEAD)
//   - DEAD_MIN    : smallest dead interval; a programmed 0 is raised to this
//   - DEAD_RST    : dead_cfg value documented as the system default
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HI_ON = 2'd1,
    ST_LO_ON = 2'd2,
    ST_DEAD  = 2'd3
  } pwm_state_e;

  localparam int unsigned DEAD_MIN = 1;
  localparam int unsigned DEAD_RST = 4;

endpackage : pwm_pkg

// File: rtl/pwm_dead_timer.sv
// pwm_dead_timer
//   Down-counter that times one dead interval.
//   Ports:
//     clk_i       system clock
//     rst_i       synchronous active-high reset (count cleared to 0)
//     load_i      load max(load_val_i, DEAD_MIN) into the counter
//     load_val_i  requested dead interval in clock cycles
//     dec_i       decrement request; the count never goes below DEAD_MIN
//     done_o      count has reached DEAD_MIN (last dead cycle)
module pwm_dead_timer
  import pwm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] load_clamped;

  // Next count: load wins over decrement; decrement saturates at DEAD_MIN so it never wraps.
  always_comb begin
    load_clamped = (load_val_i < CNT_W'(DEAD_MIN)) ? CNT_W'(DEAD_MIN) : load_val_i;
    cnt_d        = cnt_q;
    if (load_i) begin
      cnt_d = load_clamped;
    end else if (dec_i && (cnt_q > CNT_W'(DEAD_MIN))) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CNT_W'(DEAD_MIN));

endmodule : pwm_dead_timer

// File: rtl/pwm_deadtime.sv
// pwm_deadtime
//   Turns a single-ended PWM stream into a complementary half-bridge
//   gate-drive pair with a programmable dead interval around every
//   switch-over. The two drives are decoded from a single next-state
//   value, so they can never be high together. All outputs are registered.
//   Optional macro: PWM_FAULT_EN adds a latched fault shutdown; without it
//   fault_i/fault_clr_i are ignored and fault_latched_o is tied low.
//   Ports:
//     clk_i            system clock
//     rst_i            synchronous active-high reset
//     en_i             1 = run, 0 = both drives low and FSM to IDLE
//     pwm_in_i         PWM stream from the generator
//     dead_cfg_i       dead interval in clock cycles (0 behaves as 1)
//     fault_i          fault request (PWM_FAULT_EN only)
//     fault_clr_i      fault latch clear (PWM_FAULT_EN only)
//     out_hi_o         high-side drive
//     out_lo_o         low-side drive
//     dead_active_o    1 while in a dead interval
//     fault_latched_o  latched fault status
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             pwm_in_i,
  input  logic [CNT_W-1:0] dead_cfg_i,
  input  logic             fault_i,
  input  logic             fault_clr_i,
  output logic             out_hi_o,
  output logic             out_lo_o,
  output logic             dead_active_o,
  output logic             fault_latched_o
);

  logic       pwm_q;
  pwm_state_e state_q;
  pwm_state_e state_d;
  logic       target_q;
  logic       target_d;
  logic       out_hi_q;
  logic       out_hi_d;
  logic       out_lo_q;
  logic       out_lo_d;
  logic       dead_q;
  logic       dead_d;
  logic       tmr_load;
  logic       tmr_dec;
  logic       tmr_done;
  logic       fault_force;

`ifdef PWM_FAULT_EN
  logic fault_latched_q;
  logic fault_latched_d;

  // Fault latch: a set request takes priority over a clear request.
  always_comb begin
    if (fault_i) begin
      fault_latched_d = 1'b1;
    end else if (fault_clr_i) begin
      fault_latched_d = 1'b0;
    end else begin
      fault_latched_d = fault_latched_q;
    end
  end

  // Fault latch register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fault_latched_q <= 1'b0;
    end else begin
      fault_latched_q <= fault_latched_d;
    end
  end

  // The raw request is included so the drives drop on the same edge the latch sets.
  assign fault_force     = fault_i | fault_latched_q;
  assign fault_latched_o = fault_latched_q;
`else
  logic unused_fault_s;
  assign unused_fault_s  = fault_i ^ fault_clr_i;
  assign fault_force     = 1'b0;
  assign fault_latched_o = 1'b0;
`endif

  pwm_dead_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (dead_cfg_i),
    .dec_i      (tmr_dec),
    .done_o     (tmr_done)
  );

  // State register, input sampling register and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_q    <= 1'b0;
      state_q  <= ST_IDLE;
      target_q <= 1'b0;
      out_hi_q <= 1'b0;
      out_lo_q <= 1'b0;
      dead_q   <= 1'b0;
    end else begin
      pwm_q    <= pwm_in_i;
      state_q  <= state_d;
      target_q <= target_d;
      out_hi_q <= out_hi_d;
      out_lo_q <= out_lo_d;
      dead_q   <= dead_d;
    end
  end

  // Next-state logic. target_q remembers which side the current dead
  // interval leads to; a change of pwm_q during DEAD restarts the interval.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    if (!en_i || fault_force) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_DEAD;
          target_d = pwm_q;
          tmr_load = 1'b1;
        end
        ST_HI_ON: begin
          if (!pwm_q) begin
            state_d  = ST_DEAD;
            target_d = 1'b0;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_HI_ON;
          end
        end
        ST_LO_ON: begin
          if (pwm_q) begin
            state_d  = ST_DEAD;
            target_d = 1'b1;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_LO_ON;
          end
        end
        ST_DEAD: begin
          if (pwm_q != target_q) begin
            target_d = pwm_q;
            tmr_load = 1'b1;
          end else if (tmr_done) begin
            state_d = target_q ? ST_HI_ON : ST_LO_ON;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from the next state so the registered drives change on the transition edge.
  always_comb begin
    out_hi_d = 1'b0;
    out_lo_d = 1'b0;
    dead_d   = 1'b0;
    case (state_d)
      ST_HI_ON: out_hi_d = 1'b1;
      ST_LO_ON: out_lo_d = 1'b1;
      ST_DEAD:  dead_d   = 1'b1;
      default: begin
        out_hi_d = 1'b0;
        out_lo_d = 1'b0;
        dead_d   = 1'b0;
      end
    endcase
  end

  assign out_hi_o      = out_hi_q;
  assign out_lo_o      = out_lo_q;
  assign dead_active_o = dead_q;

endmodule : pwm_deadtime
